// File: rtl/instruction_encoder.sv
// Packs decoded instruction fields into RV32 R-type/I-type words and streams them,
// tagged with sequential word addresses, through a 2-entry FIFO into instruction memory.
module instruction_encoder #(
    parameter int          WORD_SIZE  = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_use_imm,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [3:0]            in_alu_op,
    input  logic [WORD_SIZE-1:0]  in_immediate,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [WORD_SIZE-1:0]  out_data,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_t                          state;
    state_t                          state_next;
    logic [ADDR_WIDTH-1:0]           counter;
    logic [ADDR_WIDTH+WORD_SIZE-1:0] fifo_mem [2];
    logic                            wr_ptr;
    logic                            rd_ptr;
    logic [1:0]                      fifo_count;

    logic                  arm;
    logic                  handshake;
    logic                  imm_ok;
    logic                  illegal;
    logic                  push;
    logic                  reject;
    logic                  pop;
    logic                  last_addr;
    logic [WORD_SIZE-1:0]  encoded;
    logic [WORD_SIZE-12:0] imm_hi;

    // An immediate fits in 12 bits only when bits [31:11] are a pure sign extension.
    assign imm_hi    = in_immediate[WORD_SIZE-1:11];
    assign imm_ok    = (&imm_hi) || (~|imm_hi);
    assign illegal   = in_use_imm && (!imm_ok || in_alu_op[3]);
    assign arm       = start && (state != RUN);
    assign handshake = in_valid && in_ready;
    assign push      = handshake && !illegal;
    assign reject    = handshake && illegal;
    assign pop       = out_valid && out_ready;
    assign last_addr = (counter == '1);

    assign in_ready  = (state == RUN) && (fifo_count < 2'd2);
    assign out_valid = (fifo_count != 2'd0);
    assign busy      = (state == RUN) || (fifo_count != 2'd0);
    assign {out_addr, out_data} = fifo_mem[rd_ptr];

    always_comb begin
        encoded = '0;
        if (in_use_imm) begin
            encoded = {in_immediate[11:0], in_rs1, in_alu_op[2:0], in_rd, 7'b0010011};
        end else begin
            encoded = {1'b0, in_alu_op[3], 5'b0, in_rs2, in_rs1, in_alu_op[2:0], in_rd, 7'b0110011};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (push && last_addr) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // The slot freed by a pop is only visible to in_ready on the following cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {counter, encoded};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Rejected bundles leave the address untouched; only the first rejection is recorded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter  <= BASE;
            error    <= 1'b0;
            err_addr <= '0;
        end else if (arm) begin
            counter  <= BASE;
            error    <= 1'b0;
            err_addr <= '0;
        end else begin
            if (push) begin
                counter <= counter + ADDR_WIDTH'(1);
            end
            if (reject) begin
                error <= 1'b1;
                if (!error) begin
                    err_addr <= counter;
                end
            end
        end
    end

endmodule
